// File: rtl/ssd_scan_ctrl.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// Each digit slot is a blanking gap followed by the lit period. New values arrive
// through a load/ack handshake and are committed only at frame boundaries, so a
// frame never mixes old and new digits.
module ssd_scan_ctrl #(
    parameter int unsigned SLOT_CYCLES  = 100000,
    parameter int unsigned BLANK_CYCLES = 1000,
    parameter int unsigned CNT_W        = 17
) (
    input  logic        clock_in,
    input  logic        reset_n,
    input  logic [15:0] value_in,
    input  logic [3:0]  dp_in,
    input  logic        load,
    output logic        load_ack,
    input  logic [3:0]  digit_en,
    input  logic        lz_suppress,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);

    typedef enum logic [0:0] {StBlank, StShow} state_e;

    localparam logic [CNT_W-1:0] SlotLast  = CNT_W'(SLOT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK_CYCLES - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [15:0]      disp_q, disp_d;
    logic [3:0]       disp_dp_q, disp_dp_d;
    logic [15:0]      stage_q, stage_d;
    logic [3:0]       stage_dp_q, stage_dp_d;
    logic             pending_q, pending_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             ack_q, ack_d;
    logic             fs_q, fs_d;
    logic             boundary;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex digit.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Slot sequencing: blank gap, then show, then advance to the next digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = (cnt_q == SlotLast) ? '0 : cnt_q + CNT_W'(1);
        unique case (state_q)
            StBlank: begin
                if (cnt_q == BlankLast) begin
                    state_d = StShow;
                end
            end
            StShow: begin
                if (cnt_q == SlotLast) begin
                    state_d = StBlank;
                    idx_d   = idx_q + 2'd1;
                end
            end
            default: state_d = StBlank;
        endcase
        boundary = (state_d == StBlank) && (idx_d == 2'd0) && (cnt_d == '0);
    end

    // Staging and commit; a load on the edge entering the boundary is merged so
    // the newest value is the one committed.
    always_comb begin
        stage_d    = load ? value_in : stage_q;
        stage_dp_d = load ? dp_in : stage_dp_q;
        pending_d  = pending_q | load;
        disp_d     = disp_q;
        disp_dp_d  = disp_dp_q;
        ack_d      = 1'b0;
        if (boundary && pending_d) begin
            disp_d    = stage_d;
            disp_dp_d = stage_dp_d;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    // Output decode from next state so the pins line up with the FSM cycle.
    always_comb begin
        logic [15:0] upper;
        logic        suppressed;
        logic        visible;
        upper      = disp_d >> {idx_d, 2'b00};
        suppressed = lz_suppress && (idx_d != 2'd0) && (upper == 16'h0000);
        visible    = (state_d == StShow) && digit_en[idx_d] && !suppressed;
        an_d       = 4'hF;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        fs_d       = boundary;
        if (visible) begin
            an_d[idx_d] = 1'b0;
            seg_d       = hex_to_seg(disp_d[{idx_d, 2'b00} +: 4]);
            dp_d        = ~disp_dp_d[idx_d];
        end
    end

    // State and output registers.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StBlank;
            cnt_q      <= '0;
            idx_q      <= 2'd0;
            disp_q     <= 16'h0000;
            disp_dp_q  <= 4'h0;
            stage_q    <= 16'h0000;
            stage_dp_q <= 4'h0;
            pending_q  <= 1'b0;
            an_q       <= 4'hF;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            ack_q      <= 1'b0;
            // Reset parks the FSM on the frame boundary, so the first cycle after
            // release is itself a frame start.
            fs_q       <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            disp_q     <= disp_d;
            disp_dp_q  <= disp_dp_d;
            stage_q    <= stage_d;
            stage_dp_q <= stage_dp_d;
            pending_q  <= pending_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            ack_q      <= ack_d;
            fs_q       <= fs_d;
        end
    end

    assign an          = an_q;
    assign seg         = seg_q;
    assign dp          = dp_q;
    assign load_ack    = ack_q;
    // Held low while in reset; pulses on the boundary cycle right after release.
    assign frame_start = fs_q & reset_n;

endmodule
